// File: rtl/instr_fetch_queue_pkg.sv
// Shared types and constants for the SPU fetch front end: instruction word width,
// the LNOP filler shown on empty issue slots, and the queue entry layout.
package spu_fetch_pkg;

   localparam int WORD = 32;
   localparam logic [WORD-1:0] LNOP = 32'h0020_0000;
   localparam int POP_MAX = 2;

   typedef struct packed {
      logic [WORD-1:0] instr;
      logic [WORD-1:0] pc;
   } fq_entry_t;

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Bundles the IMEM line bus and the decode/issue head window of the fetch queue.
interface instr_fetch_queue_if
   import spu_fetch_pkg::*;
#(
   parameter int FETCH_W = 2,
   parameter int IMEM_AW = 11
);
   logic [IMEM_AW-1:0]      imem_addr;
   logic [FETCH_W*WORD-1:0] imem_rdata;
   logic [1:0]              pop_cnt;
   logic [WORD-1:0]         instr0;
   logic [WORD-1:0]         instr1;
   logic                    valid0;
   logic                    valid1;
   logic [WORD-1:0]         pc0;

   modport master (
      output imem_addr, instr0, instr1, valid0, valid1, pc0,
      input  imem_rdata, pop_cnt
   );

   modport slave (
      input  imem_addr, instr0, instr1, valid0, valid1, pc0,
      output imem_rdata, pop_cnt
   );
endinterface

// File: rtl/instr_fetch_queue_fetch_queue.sv
// Circular buffer of fetched instructions: up to FETCH_W pushes and 2 pops per cycle,
// single-cycle flush; head and head+1 are read combinationally.
module fetch_queue
   import spu_fetch_pkg::*;
#(
   parameter  int FETCH_W  = 2,
   parameter  int FQ_DEPTH = 8,
   localparam int PTR_W    = $clog2(FQ_DEPTH),
   localparam int CNT_W    = PTR_W + 1,
   localparam int PUSH_W   = $clog2(FETCH_W + 1)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          flush,
   input  logic [PUSH_W-1:0]             push_cnt,
   input  fq_entry_t [FETCH_W-1:0]       push_data,
   input  logic [1:0]                    pop_cnt,
   output fq_entry_t                     head0,
   output logic [WORD-1:0]               head1_instr,
   output logic [CNT_W-1:0]              count
);

   fq_entry_t        mem [FQ_DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] pop_eff;

   // Issue may ask for more than is buffered; only what exists is consumed.
   always_comb begin
      pop_eff = (pop_cnt > 2'(POP_MAX)) ? CNT_W'(POP_MAX) : CNT_W'(pop_cnt);
      if (pop_eff > count) pop_eff = count;
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         rd_ptr <= rd_ptr + PTR_W'(pop_eff);
         wr_ptr <= wr_ptr + PTR_W'(push_cnt);
         count  <= count - pop_eff + CNT_W'(push_cnt);
      end
   end

   // push_cnt is already zero under reset/flush, so storage needs no reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < FETCH_W; i++) begin
         if (i < int'(push_cnt)) mem[wr_ptr + PTR_W'(i)] <= push_data[i];
      end
   end

   assign head0       = mem[rd_ptr];
   assign head1_instr = mem[rd_ptr + PTR_W'(1)].instr;

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch front end: owns the PC, decides when an IMEM line is fetched and which slots are
// enqueued, and presents the queue head to issue. Define IF_PERF_EN for perf counters.
module instr_fetch_queue
   import spu_fetch_pkg::*;
#(
   parameter  int FETCH_W  = 2,
   parameter  int FQ_DEPTH = 8,
   parameter  int IMEM_AW  = 11,
   localparam int CNT_W    = $clog2(FQ_DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stop_and_signal,
   input  logic             redirect,
   input  logic [WORD-1:0]  bta,
   output logic [WORD-1:0]  pc,
   output logic [CNT_W-1:0] fq_count,
`ifdef IF_PERF_EN
   output logic [31:0]      perf_fetch_lines,
   output logic [31:0]      perf_full_stalls,
   output logic [31:0]      perf_flushes,
`endif
   instr_fetch_queue_if.master bus
);

   localparam int LINE_B = FETCH_W * 4;
   localparam int OFF_W  = $clog2(FETCH_W);
   localparam int PUSH_W = $clog2(FETCH_W + 1);

   logic [WORD-1:0]          line_base;
   logic [OFF_W-1:0]         off;
   logic                     fire;
   logic [PUSH_W-1:0]        push_cnt;
   fq_entry_t [FETCH_W-1:0]  push_data;
   fq_entry_t                head0;
   logic [WORD-1:0]          head1_instr;
   int                       slot;

   assign off           = pc[2 +: OFF_W];
   assign line_base     = pc & ~WORD'(LINE_B - 1);
   assign bus.imem_addr = line_base[IMEM_AW-1:0];

   // Free space is judged before this cycle's pops, so a fire never depends on issue.
   assign fire = !reset && !stop_and_signal && !redirect &&
                 ((CNT_W'(FQ_DEPTH) - fq_count) >= CNT_W'(FETCH_W));

   assign push_cnt = fire ? PUSH_W'(FETCH_W - int'(off)) : '0;

   // Slots before the PC's word offset are skipped; the rest are compacted to the front.
   always_comb begin
      push_data = '0;
      slot      = 0;
      for (int i = 0; i < FETCH_W; i++) begin
         slot = int'(off) + i;
         if (slot < FETCH_W) begin
            push_data[i].instr = bus.imem_rdata[(FETCH_W-1-slot)*WORD +: WORD];
            push_data[i].pc    = line_base + WORD'(slot * 4);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset)         pc <= '0;
      else if (redirect) pc <= bta & ~WORD'(3);
      else if (fire)     pc <= line_base + WORD'(LINE_B);
   end

   fetch_queue #(
      .FETCH_W  (FETCH_W),
      .FQ_DEPTH (FQ_DEPTH)
   ) u_fq (
      .clk         (clk),
      .reset       (reset),
      .flush       (redirect),
      .push_cnt    (push_cnt),
      .push_data   (push_data),
      .pop_cnt     (bus.pop_cnt),
      .head0       (head0),
      .head1_instr (head1_instr),
      .count       (fq_count)
   );

   assign bus.valid0 = fq_count >= CNT_W'(1);
   assign bus.valid1 = fq_count >= CNT_W'(2);
   assign bus.instr0 = bus.valid0 ? head0.instr : LNOP;
   assign bus.instr1 = bus.valid1 ? head1_instr : LNOP;
   assign bus.pc0    = bus.valid0 ? head0.pc : '0;

`ifdef IF_PERF_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_fetch_lines <= '0;
         perf_full_stalls <= '0;
         perf_flushes     <= '0;
      end else begin
         if (fire) perf_fetch_lines <= sat_inc(perf_fetch_lines);
         if (!stop_and_signal && !fire && !redirect) perf_full_stalls <= sat_inc(perf_full_stalls);
         if (redirect) perf_flushes <= sat_inc(perf_flushes);
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: a queue-based model predicts the visible state each
// cycle, a separate monitor compares it with the DUT on the falling edge.
module tb_instr_fetch_queue;
   import spu_fetch_pkg::*;

   localparam int FW    = 2;
   localparam int DEPTH = 8;
   localparam int AW    = 11;
   localparam int CW    = $clog2(DEPTH) + 1;
   localparam int LINE  = FW * 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          stop = 1'b0;
   logic          redir = 1'b0;
   logic [31:0]   bta = '0;
   logic [31:0]   pc;
   logic [CW-1:0] fq_count;
`ifdef IF_PERF_EN
   logic [31:0]   perf_fetch_lines, perf_full_stalls, perf_flushes;
`endif

   always #5 clk = ~clk;

   instr_fetch_queue_if #(.FETCH_W(FW), .IMEM_AW(AW)) bus ();

   instr_fetch_queue #(.FETCH_W(FW), .FQ_DEPTH(DEPTH), .IMEM_AW(AW)) dut (
      .clk             (clk),
      .reset           (reset),
      .stop_and_signal (stop),
      .redirect        (redir),
      .bta             (bta),
      .pc              (pc),
      .fq_count        (fq_count),
`ifdef IF_PERF_EN
      .perf_fetch_lines(perf_fetch_lines),
      .perf_full_stalls(perf_full_stalls),
      .perf_flushes    (perf_flushes),
`endif
      .bus             (bus)
   );

   logic [31:0] imem [512];

   // IMEM: combinational line read, slot 0 in the most significant word.
   always_comb begin
      bus.imem_rdata = '0;
      for (int k = 0; k < FW; k++)
         bus.imem_rdata[(FW-1-k)*32 +: 32] = imem[(int'(bus.imem_addr) >> 2) + k];
   end

   typedef struct packed {
      logic          v0, v1;
      logic [31:0]   i0, i1, pc0, pc;
      logic [CW-1:0] cnt;
      logic [AW-1:0] addr;
`ifdef IF_PERF_EN
      logic [31:0]   pf, ps, pr;
`endif
   } obs_t;

   fq_entry_t   mq[$];
   logic [31:0] mpc = '0;
   int          m_fl = 0, m_st = 0, m_rf = 0;
   obs_t        sb[$];
   int          total = 0;
   int          bad = 0;

   function automatic obs_t model_obs();
      obs_t        o;
      int          n;
      logic [31:0] base;
      n      = mq.size();
      base   = mpc - (mpc % LINE);
      o.v0   = (n >= 1);
      o.v1   = (n >= 2);
      o.i0   = (n >= 1) ? mq[0].instr : LNOP;
      o.i1   = (n >= 2) ? mq[1].instr : LNOP;
      o.pc0  = (n >= 1) ? mq[0].pc : 32'd0;
      o.pc   = mpc;
      o.cnt  = CW'(n);
      o.addr = base[AW-1:0];
`ifdef IF_PERF_EN
      o.pf = m_fl; o.ps = m_st; o.pr = m_rf;
`endif
      return o;
   endfunction

   task automatic model_step(input logic r, input logic s, input logic rd,
                             input logic [31:0] b, input int p);
      int          n;
      int          popn;
      bit          fire;
      logic [31:0] base;
      logic [31:0] a;
      n    = mq.size();
      popn = (p < n) ? p : n;
      if (r) begin
         mq.delete(); mpc = '0; m_fl = 0; m_st = 0; m_rf = 0;
         return;
      end
      if (rd) begin
         mq.delete(); mpc = b & 32'hFFFF_FFFC; m_rf++;
         return;
      end
      fire = !s && ((DEPTH - n) >= FW);
      if (fire) m_fl++;
      else if (!s) m_st++;
      repeat (popn) void'(mq.pop_front());
      if (fire) begin
         base = mpc - (mpc % LINE);
         for (int w = int'((mpc % LINE) / 4); w < FW; w++) begin
            a = base + 32'(w * 4);
            mq.push_back('{instr: imem[int'((a >> 2) & 32'd511)], pc: a});
         end
         mpc = base + LINE;
      end
   endtask

   task automatic cyc(input logic r, input logic s, input logic rd,
                      input logic [31:0] b, input int p);
      @(posedge clk);
      #1;
      sb.push_back(model_obs());
      reset = r; stop = s; redir = rd; bta = b; bus.pop_cnt = 2'(p);
      model_step(r, s, rd, b, p);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
      end
   endtask

   initial begin : monitor
      obs_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("valid0",   32'(bus.valid0),    32'(e.v0));
            chk("valid1",   32'(bus.valid1),    32'(e.v1));
            chk("instr0",   bus.instr0,         e.i0);
            chk("instr1",   bus.instr1,         e.i1);
            chk("pc0",      bus.pc0,            e.pc0);
            chk("pc",       pc,                 e.pc);
            chk("fq_count", 32'(fq_count),      32'(e.cnt));
            chk("imem_addr",32'(bus.imem_addr), 32'(e.addr));
`ifdef IF_PERF_EN
            chk("perf_fetch_lines", perf_fetch_lines, e.pf);
            chk("perf_full_stalls", perf_full_stalls, e.ps);
            chk("perf_flushes",     perf_flushes,     e.pr);
`endif
         end
      end
   end

   initial begin : driver
      int wait_cyc;
      bus.pop_cnt = 2'd0;
      for (int k = 0; k < 512; k++) imem[k] = $urandom;

      cyc(1, 0, 0, 32'h0, 0);
      cyc(1, 0, 0, 32'h0, 0);
      // fill from reset until full, then hold
      repeat (6) cyc(0, 0, 0, 32'h0, 0);
      // drain in pairs while fetch refills
      repeat (8) cyc(0, 0, 0, 32'h0, 2);
      repeat (4) cyc(0, 0, 0, 32'h0, 0);
      // redirect with a full queue to an unaligned target
      cyc(0, 0, 1, 32'h14, 0);
      cyc(0, 0, 0, 32'h0, 0);
      // single entry, pop of two under stop
      cyc(0, 1, 0, 32'h0, 2);
      cyc(0, 1, 0, 32'h0, 0);
      repeat (3) cyc(0, 0, 0, 32'h0, 0);
      // stop with six entries drains in three cycles
      repeat (4) cyc(0, 1, 0, 32'h0, 2);
      // redirect during stop loads pc only
      cyc(0, 1, 1, 32'h0000_0103, 0);
      cyc(0, 1, 0, 32'h0, 0);
      repeat (3) cyc(0, 0, 0, 32'h0, 1);
      // reset in the middle of activity
      cyc(1, 0, 0, 32'h0, 1);
      repeat (3) cyc(0, 0, 0, 32'h0, 1);
      // pc wrap across 2^32
      cyc(0, 0, 1, 32'hFFFF_FFFC, 0);
      repeat (3) cyc(0, 0, 0, 32'h0, 2);

      repeat (3000) begin
         logic        r, s, rd;
         logic [31:0] b;
         r  = ($urandom_range(0, 199) == 0);
         s  = ($urandom_range(0, 99) < 15);
         rd = ($urandom_range(0, 99) < 5);
         b  = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 2047));
         cyc(r, s, rd, b, $urandom_range(0, 2));
      end
      repeat (6) cyc(0, 1, 0, 32'h0, 2);

      wait_cyc = 0;
      while (sb.size() > 0 && wait_cyc < 10) begin
         @(negedge clk);
         wait_cyc++;
      end
      #2;
      if (sb.size() > 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_drain: actual=%0d pending required=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
